game_area_ctrl: RTL

- Owns the playfield row store: ROWS rows of DW bits, one row per board line.
- Shares the single storage port between three users: the pixel renderer (row fetch during active lines), the game-logic port (row read/write under a req/gnt handshake) and an internal line-clear sequencer.
- The line-clear sequencer removes full rows, compacts the board downward and reports how many lines were cleared.
- Sits between the game FSM and the draw logic; the renderer's row address/data bus connects directly to the disp_* port.

---
 rtl/game_area_ctrl_pkg.sv | 26 ++
 rtl/game_area_rowmem.sv | 42 ++++
 rtl/game_area_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/game_area_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_area_ctrl_pkg
// Brief   : Shared sizes, row patterns and sequencer state codes.
// Revision: 1.0
// ============================================================================
package game_area_ctrl_pkg;
    localparam int ROWS = 20;
    localparam int AW   = 5;
    localparam int DW   = 12;

    localparam logic [DW-1:0] ROW_FULL  = 12'hFFF;
    localparam logic [DW-1:0] ROW_EMPTY = 12'h801;

    localparam logic [AW-1:0]        ROWS_A   = AW'(ROWS);
    localparam logic signed [AW:0]   PTR_LAST = (AW+1)'(ROWS-1);
    localparam logic signed [AW:0]   PTR_ONE  = (AW+1)'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CHK  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
endpackage
`default_nettype wire

// File: rtl/game_area_rowmem.sv
`default_nettype none
// ============================================================================
// Module  : game_area_rowmem
// Brief   : Single-port playfield row store with registered read data.
// Revision: 1.0
// ============================================================================
module game_area_rowmem
    import game_area_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_re,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [ROWS];
    logic [DW-1:0] r_rdata;
    logic          w_in_range;

    // Addresses past the last row read as zero and swallow writes.
    assign w_in_range = (i_addr < ROWS_A);
    assign o_rdata    = r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                r_mem[i] <= ROW_EMPTY;
            end
            r_rdata <= '0;
        end else begin
            if (i_we && w_in_range) begin
                r_mem[i_addr] <= i_wdata;
            end
            if (i_re) begin
                r_rdata <= w_in_range ? r_mem[i_addr] : '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/game_area_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : game_area_ctrl
// Brief   : Arbitrates the row store between renderer, game logic and the
//           line-clear sequencer that compacts the board downward.
// Revision: 1.0
// ============================================================================
module game_area_ctrl
    import game_area_ctrl_pkg::*;
(
    input  logic          vga_clk,
    input  logic          rst,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_data,
    output logic          disp_valid,
    input  logic          lg_req,
    input  logic          lg_we,
    input  logic [AW-1:0] lg_addr,
    input  logic [DW-1:0] lg_wdata,
    output logic          lg_gnt,
    output logic [DW-1:0] lg_rdata,
    output logic          lg_rvalid,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [AW-1:0] clr_lines
);
    logic [2:0]        r_state, w_state_nxt;
    logic signed [AW:0] r_src, r_dst, w_src_nxt, w_dst_nxt, w_src_dec, w_dst_dec;
    logic [AW-1:0]     r_cnt, w_cnt_nxt;
    logic [DW-1:0]     r_latch, w_latch_nxt;
    logic [AW-1:0]     r_clr_lines;

    logic              w_mem_re, w_mem_we;
    logic [AW-1:0]     w_mem_addr;
    logic [DW-1:0]     w_mem_wdata, w_mem_rdata;

    logic              r_disp_v, r_lg_v;
    logic [DW-1:0]     r_disp_hold, r_lg_hold;

    game_area_rowmem u_rowmem (
        .clk     (vga_clk),
        .rst     (rst),
        .i_re    (w_mem_re),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign w_src_dec = r_src - PTR_ONE;
    assign w_dst_dec = r_dst - PTR_ONE;
    assign lg_gnt    = lg_req & ~disp_req & (r_state == S_IDLE) & ~clr_start;

    // Storage port mux: display, then sequencer, then game logic.
    always_comb begin
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (disp_req) begin
            w_mem_re   = 1'b1;
            w_mem_addr = disp_addr;
        end else if (r_state == S_RD) begin
            w_mem_re   = 1'b1;
            w_mem_addr = r_src[AW-1:0];
        end else if (r_state == S_WR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_dst[AW-1:0];
            w_mem_wdata = r_latch;
        end else if ((r_state == S_FILL) && !r_dst[AW]) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_dst[AW-1:0];
            w_mem_wdata = ROW_EMPTY;
        end else if (lg_gnt) begin
            w_mem_re    = ~lg_we;
            w_mem_we    = lg_we;
            w_mem_addr  = lg_addr;
            w_mem_wdata = lg_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_cnt_nxt   = r_cnt;
        w_latch_nxt = r_latch;
        case (r_state)
            S_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = S_RD;
                    w_src_nxt   = PTR_LAST;
                    w_dst_nxt   = PTR_LAST;
                    w_cnt_nxt   = '0;
                end
            end
            S_RD: begin
                if (!disp_req) begin
                    w_state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (w_mem_rdata == ROW_FULL) begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_src_nxt   = w_src_dec;
                    w_state_nxt = w_src_dec[AW] ? S_FILL : S_RD;
                end else if (r_src == r_dst) begin
                    w_src_nxt   = w_src_dec;
                    w_dst_nxt   = w_dst_dec;
                    w_state_nxt = w_src_dec[AW] ? S_FILL : S_RD;
                end else begin
                    w_latch_nxt = w_mem_rdata;
                    w_state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (!disp_req) begin
                    w_src_nxt   = w_src_dec;
                    w_dst_nxt   = w_dst_dec;
                    w_state_nxt = w_src_dec[AW] ? S_FILL : S_RD;
                end
            end
            S_FILL: begin
                if (r_dst[AW]) begin
                    w_state_nxt = S_DONE;
                end else if (!disp_req) begin
                    w_dst_nxt = w_dst_dec;
                    if (w_dst_dec[AW]) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_cnt       <= '0;
            r_latch     <= '0;
            r_clr_lines <= '0;
            r_disp_v    <= 1'b0;
            r_lg_v      <= 1'b0;
            r_disp_hold <= '0;
            r_lg_hold   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_src       <= w_src_nxt;
            r_dst       <= w_dst_nxt;
            r_cnt       <= w_cnt_nxt;
            r_latch     <= w_latch_nxt;
            // Count is final once FILL completes, so it lines up with clr_done.
            if ((r_state == S_FILL) && (w_state_nxt == S_DONE)) begin
                r_clr_lines <= r_cnt;
            end
            r_disp_v    <= disp_req;
            r_lg_v      <= lg_gnt & ~lg_we;
            r_disp_hold <= disp_data;
            r_lg_hold   <= lg_rdata;
        end
    end

    assign disp_valid = r_disp_v;
    assign disp_data  = r_disp_v ? w_mem_rdata : r_disp_hold;
    assign lg_rvalid  = r_lg_v;
    assign lg_rdata   = r_lg_v ? w_mem_rdata : r_lg_hold;
    assign clr_busy   = (r_state != S_IDLE);
    assign clr_done   = (r_state == S_DONE);
    assign clr_lines  = r_clr_lines;
endmodule
`default_nettype wire
